// File: rtl/morse_pkg.sv
// morse_pkg: shared state, timing and lookup types
// for the ASCII-to-Morse keyer.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MARK,
    SYM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int SYM_GAP_UNITS    = 1;
  localparam int CHAR_GAP_UNITS   = 3;
  localparam int WORD_EXTRA_UNITS = 4;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef struct packed {
    logic       supported;
    logic       is_space;
    logic [2:0] len;
    logic [4:0] pat;
  } lut_t;

  function automatic logic [1:0] last_unit(input int units);
    return 2'(units - 1);
  endfunction

endpackage

// File: rtl/morse_lut.sv
// morse_lut: combinational ASCII to Morse ROM.
// pat is LSB-first, 1 = dash, 0 = dot.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] code,
  output lut_t       res
);

  logic [7:0] up;
  logic [2:0] len;
  logic [4:0] seq;
  logic [4:0] rev;

  // fold case; seq holds elements first-to-last, right-aligned
  always_comb begin
    up  = code;
    len = 3'd0;
    seq = 5'b0;
    if (code >= 8'h61 && code <= 8'h7a)
      up = code - 8'h20;
    unique case (up)
      "A": {len, seq} = {3'd2, 5'b00001};
      "B": {len, seq} = {3'd4, 5'b01000};
      "C": {len, seq} = {3'd4, 5'b01010};
      "D": {len, seq} = {3'd3, 5'b00100};
      "E": {len, seq} = {3'd1, 5'b00000};
      "F": {len, seq} = {3'd4, 5'b00010};
      "G": {len, seq} = {3'd3, 5'b00110};
      "H": {len, seq} = {3'd4, 5'b00000};
      "I": {len, seq} = {3'd2, 5'b00000};
      "J": {len, seq} = {3'd4, 5'b00111};
      "K": {len, seq} = {3'd3, 5'b00101};
      "L": {len, seq} = {3'd4, 5'b00100};
      "M": {len, seq} = {3'd2, 5'b00011};
      "N": {len, seq} = {3'd2, 5'b00010};
      "O": {len, seq} = {3'd3, 5'b00111};
      "P": {len, seq} = {3'd4, 5'b00110};
      "Q": {len, seq} = {3'd4, 5'b01101};
      "R": {len, seq} = {3'd3, 5'b00010};
      "S": {len, seq} = {3'd3, 5'b00000};
      "T": {len, seq} = {3'd1, 5'b00001};
      "U": {len, seq} = {3'd3, 5'b00001};
      "V": {len, seq} = {3'd4, 5'b00001};
      "W": {len, seq} = {3'd3, 5'b00011};
      "X": {len, seq} = {3'd4, 5'b01001};
      "Y": {len, seq} = {3'd4, 5'b01011};
      "Z": {len, seq} = {3'd4, 5'b01100};
      "0": {len, seq} = {3'd5, 5'b11111};
      "1": {len, seq} = {3'd5, 5'b01111};
      "2": {len, seq} = {3'd5, 5'b00111};
      "3": {len, seq} = {3'd5, 5'b00011};
      "4": {len, seq} = {3'd5, 5'b00001};
      "5": {len, seq} = {3'd5, 5'b00000};
      "6": {len, seq} = {3'd5, 5'b10000};
      "7": {len, seq} = {3'd5, 5'b11000};
      "8": {len, seq} = {3'd5, 5'b11100};
      "9": {len, seq} = {3'd5, 5'b11110};
      default: ;
    endcase
  end

  // bit-reverse so the first element lands in bit 0
  always_comb begin
    for (int i = 0; i < 5; i++)
      rev[i] = seq[4-i];
    res.supported = (len != 3'd0);
    res.is_space  = (code == ASCII_SPACE);
    res.len       = len;
    res.pat       = rev >> (3'd5 - len);
  end

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: keys received ASCII bytes as Morse
// on a single on/off line, with a one-byte buffer.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 720000,
  parameter int UNIT_W      = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_key,
  output logic       o_busy,
  output logic       o_overflow
);

  state_t            state;
  state_t            state_n;
  logic [2:0]        sync;
  logic              rise;
  logic [7:0]        hold_data;
  logic              hold_valid;
  lut_t              lut;
  logic              take;
  logic [4:0]        pat;
  logic [2:0]        rem;
  logic [UNIT_W-1:0] cnt;
  logic [1:0]        units;
  logic [1:0]        last_u;
  logic              tick;
  logic              done;
  logic              restart;
  logic              key;
  logic              ovf;

  morse_lut u_lut (
    .code (hold_data),
    .res  (lut)
  );

  assign rise    = sync[1] & ~sync[2];
  assign tick    = (cnt == UNIT_W'(UNIT_CYCLES - 1));
  assign done    = tick & (units == last_u);
  assign restart = done | (state_n != state) | (state == IDLE);

  assign o_key      = key;
  assign o_overflow = ovf;
  assign o_busy     = (state != IDLE) | hold_valid;

  // two-flop synchroniser plus one flop for edge detect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= '0;
    else          sync <= {sync[1:0], i_valid};
  end

  // holding buffer; a new byte wins over the clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (rise && hold_valid && !take) begin
        ovf <= 1'b1;
      end else if (rise) begin
        hold_data  <= i_data;
        hold_valid <= 1'b1;
      end else if (take) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // last unit index of the current state
  always_comb begin
    last_u = 2'd0;
    unique case (state)
      MARK:     last_u = pat[0] ? last_unit(DASH_UNITS)
                                : last_unit(DOT_UNITS);
      SYM_GAP:  last_u = last_unit(SYM_GAP_UNITS);
      CHAR_GAP: last_u = last_unit(CHAR_GAP_UNITS);
      WORD_GAP: last_u = last_unit(WORD_EXTRA_UNITS);
      default:  ;
    endcase
  end

  // next state; a byte held at gap expiry loads at once
  always_comb begin
    state_n = state;
    take    = 1'b0;
    unique case (state)
      IDLE:    if (hold_valid) state_n = LOAD;
      LOAD:    take = 1'b1;
      MARK:    if (done)
                 state_n = (rem > 3'd1) ? SYM_GAP : CHAR_GAP;
      SYM_GAP: if (done) state_n = MARK;
      CHAR_GAP, WORD_GAP:
        if (done) begin
          state_n = IDLE;
          take    = hold_valid;
        end
      default: state_n = IDLE;
    endcase
    if (take) begin
      if (lut.supported)     state_n = MARK;
      else if (lut.is_space) state_n = WORD_GAP;
      else                   state_n = IDLE;
    end
  end

  // state register and registered key line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      key   <= 1'b0;
    end else begin
      state <= state_n;
      key   <= (state_n == MARK);
    end
  end

  // pattern shifter and remaining-element count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pat <= '0;
      rem <= '0;
    end else if (take) begin
      pat <= lut.pat;
      rem <= lut.len;
    end else if (state == MARK && done) begin
      pat <= pat >> 1;
      rem <= rem - 3'd1;
    end
  end

  // unit timer, restarted on every state entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt   <= '0;
      units <= '0;
    end else if (restart) begin
      cnt   <= '0;
      units <= '0;
    end else if (tick) begin
      cnt   <= '0;
      units <= units + 2'd1;
    end else begin
      cnt <= cnt + UNIT_W'(1);
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: vector table, corner sequences and
// random traffic against a dot/dash string model.
module tb_morse_keyer;
  import morse_pkg::*;

  localparam int U = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       key;
  logic       busy;
  logic       ovf;
  logic [7:0] lut_code = 8'h00;
  lut_t       lut_res;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_cnt  = 0;
  int exp_q[$];
  int got_q[$];

  typedef struct packed {
    logic [7:0]  ch;
    logic [39:0] pat;
    logic [7:0]  busy;
  } vec_t;

  localparam logic [39:0] LETTERS [26] = '{
    40'(".-"), 40'("-..."), 40'("-.-."), 40'("-.."),
    40'("."), 40'("..-."), 40'("--."), 40'("...."),
    40'(".."), 40'(".---"), 40'("-.-"), 40'(".-.."),
    40'("--"), 40'("-."), 40'("---"), 40'(".--."),
    40'("--.-"), 40'(".-."), 40'("..."), 40'("-"),
    40'("..-"), 40'("...-"), 40'(".--"), 40'("-..-"),
    40'("-.--"), 40'("--..")
  };
  localparam logic [39:0] DIGITS [10] = '{
    40'("-----"), 40'(".----"), 40'("..---"),
    40'("...--"), 40'("....-"), 40'("....."),
    40'("-...."), 40'("--..."), 40'("---.."),
    40'("----.")
  };

  morse_keyer #(
    .UNIT_CYCLES (U),
    .UNIT_W      (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_valid    (valid),
    .o_key      (key),
    .o_busy     (busy),
    .o_overflow (ovf)
  );

  morse_lut u_lut (
    .code (lut_code),
    .res  (lut_res)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (ovf === 1'b1) ovf_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at %0t, expected finish", $time);
    $fatal(1);
  end

  function automatic logic [39:0] morse_of(input logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (u >= 8'h61 && u <= 8'h7a) u = u - 8'h20;
    if (u >= 8'h41 && u <= 8'h5a) return LETTERS[u - 8'h41];
    if (u >= 8'h30 && u <= 8'h39) return DIGITS[u - 8'h30];
    if (u == 8'h20) return 40'h20;
    return 40'h0;
  endfunction

  function automatic logic [7:0] pick_keyable();
    int r;
    r = $urandom_range(0, 36);
    if (r < 26) return 8'(r) + (($urandom_range(0, 1) == 1) ? 8'h61 : 8'h41);
    if (r < 36) return 8'(r - 26) + 8'h30;
    return 8'h20;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic check_wave(input string name);
    int bad;
    int n;
    bad = -1;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
    n_checks++;
    if (bad < 0 && got_q.size() == exp_q.size()) begin
      n_pass++;
    end else if (bad < 0) begin
      $display("FAIL %s: wave length %0d, expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      $display("FAIL %s: cycle %0d symbol %0d, expected %0d", name, bad, got_q[bad], exp_q[bad]);
    end
  endtask

  // 0 = idle, 1 = busy with key off, 2 = key on
  task automatic exp_start();
    exp_q = {0, 0, 1, 1};
  endtask

  task automatic exp_char(input logic [39:0] m);
    logic [7:0] els[$];
    for (int i = 4; i >= 0; i--)
      if (m[i*8 +: 8] != 8'h00) els.push_back(m[i*8 +: 8]);
    if (els.size() == 1 && els[0] == 8'h20) begin
      repeat (4*U) exp_q.push_back(1);
    end else begin
      foreach (els[i]) begin
        repeat ((els[i] == 8'h2d) ? 3*U : U) exp_q.push_back(2);
        repeat ((i == els.size() - 1) ? 3*U : U) exp_q.push_back(1);
      end
    end
  endtask

  task automatic capture();
    bit seen;
    int v;
    seen = 1'b0;
    got_q = {};
    @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      v = busy ? (key ? 2 : 1) : (key ? 3 : 0);
      if (seen && v == 0) return;
      if (v != 0) seen = 1'b1;
      got_q.push_back(v);
    end
    n_checks++;
    $display("FAIL capture_bound: busy=%0b after 600 cycles, expected 0", busy);
  endtask

  task automatic drive(input logic [7:0] c, input int hold);
    @(negedge clk);
    data  = c;
    valid = 1'b1;
    repeat (hold) @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic run_seq(input logic [7:0] cs[$], input int gap,
                         input int n_keyed, input int n_drop,
                         input string name);
    int d0;
    d0 = ovf_cnt;
    fork
      begin
        foreach (cs[k]) begin
          drive(cs[k], 3);
          repeat (gap) @(negedge clk);
        end
      end
      capture();
    join
    exp_start();
    for (int k = 0; k < n_keyed; k++) exp_char(morse_of(cs[k]));
    check_wave(name);
    check({name, "_ovf"}, ovf_cnt - d0, n_drop);
  endtask

  initial begin
    vec_t vecs [8];
    int   d0;
    int   nb;

    vecs = '{
      '{8'h45, 40'("."),     8'd18},
      '{8'h41, 40'(".-"),    8'd34},
      '{8'h61, 40'(".-"),    8'd34},
      '{8'h23, 40'h0,        8'd2},
      '{8'h20, 40'h20,       8'd18},
      '{8'h35, 40'("....."), 8'd50},
      '{8'h30, 40'("-----"), 8'd90},
      '{8'h71, 40'("--.-"),  8'd66}
    };

    repeat (3) @(negedge clk);
    check("rst_key", key, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    for (int c = 0; c < 256; c++) begin
      logic [39:0] m;
      lut_t        e;
      int          n;
      lut_code = 8'(c);
      #1;
      m = morse_of(8'(c));
      e = '0;
      n = 0;
      for (int i = 4; i >= 0; i--)
        if (m[i*8 +: 8] != 8'h00) begin
          if (m[i*8 +: 8] == 8'h2d) e.pat[n] = 1'b1;
          n++;
        end
      if (c == 32) e.is_space = 1'b1;
      else if (n > 0) begin
        e.supported = 1'b1;
        e.len       = 3'(n);
      end
      check($sformatf("lut_%02h", c), lut_res, e);
    end

    foreach (vecs[v]) begin
      d0 = ovf_cnt;
      fork
        drive(vecs[v].ch, 3);
        capture();
      join
      exp_start();
      exp_char(vecs[v].pat);
      check_wave($sformatf("vec_%02h_wave", vecs[v].ch));
      nb = 0;
      foreach (got_q[i]) if (got_q[i] != 0) nb++;
      check($sformatf("vec_%02h_busy", vecs[v].ch), nb, vecs[v].busy);
      check($sformatf("vec_%02h_ovf", vecs[v].ch), ovf_cnt - d0, 0);
    end

    run_seq({8'h53, 8'h4f}, 2, 2, 0, "s_then_o");
    run_seq({8'h4f, 8'h45, 8'h54}, 1, 2, 1, "o_drop_third");
    run_seq({8'h45, 8'h20}, 3, 2, 0, "e_then_space");

    // second edge lands on the LOAD cycle of the first
    d0 = ovf_cnt;
    fork
      begin
        @(negedge clk);
        data  = 8'h45;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        data = 8'h54;
        repeat (2) @(negedge clk);
        valid = 1'b0;
      end
      capture();
    join
    exp_start();
    exp_char(morse_of(8'h45));
    exp_char(morse_of(8'h54));
    check_wave("edge_on_load");
    check("edge_on_load_ovf", ovf_cnt - d0, 0);

    // level held high keys once only
    fork
      begin
        @(negedge clk);
        data  = 8'h45;
        valid = 1'b1;
      end
      capture();
    join
    exp_start();
    exp_char(morse_of(8'h45));
    check_wave("held_level");
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("held_no_repeat", nb, 0);
    valid = 1'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of a dash
    drive(8'h54, 3);
    repeat (5) @(negedge clk);
    check("pre_rst_key", key, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_key", key, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_seq({8'h54}, 1, 1, 0, "t_after_rst");

    for (int r = 0; r < 24; r++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = pick_keyable();
      if ($urandom_range(0, 2) == 0) begin
        a = 8'($urandom_range(0, 255));
        run_seq({a}, 1, 1, 0, $sformatf("rnd%0d_%02h", r, a));
      end else begin
        b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                        : pick_keyable();
        run_seq({a, b}, $urandom_range(1, 6), 2, 0,
                $sformatf("rnd%0d_%02h_%02h", r, a, b));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
Downstream consumer of the UART receiver byte stream. Takes each received ASCII byte and emits the corresponding International Morse sequence as a single on/off key line, which drives the buzzer/LED. Includes an input synchroniser and edge detector, because the receiver's data-valid is a level from a divided clock domain. Also includes a one-byte holding buffer, so a byte arriving mid-character is not lost.

Parameters:
UNIT_CYCLES, 720000, i_clk cycles per Morse time unit (60 ms at 12 MHz); must be >= 2
UNIT_W, 20, width of the unit counter; must satisfy 2^UNIT_W > UNIT_CYCLES

Ports:
i_clk  input  1  system clock; all state on rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_data  input  8  ASCII byte from receiver; stable while i_valid high
i_valid  input  1  receiver data-ready level; each 0->1 transition marks one new byte
o_key  output  1  1 = tone/light on
o_busy  output  1  high while a byte is held or being keyed
o_overflow  output  1  one-cycle pulse when a byte is dropped

Behaviour:
- Reset (async, i_rst_n=0): o_key=0, o_busy=0, o_overflow=0; FSM=IDLE; holding buffer empty; synchroniser flops=0; counters=0. Reset mid-MARK drops o_key immediately.
- i_valid passes through a 2-flop synchroniser plus a third flop for edge detection. Rising edge = sync2 & ~sync3.
- On a detected edge, i_data is captured into the holding register and hold_valid is set.
  - If hold_valid is already 1 at that edge, the new byte is discarded and o_overflow pulses for 1 cycle.
  - A held byte is never overwritten.
- Character lookup (combinational):
  - 'A'-'Z', 'a'-'z' (case folded), '0'-'9': 5-bit pattern plus 3-bit length 1..5. Patterns are LSB-first, 1=dash, 0=dot.
  - 0x20 (space): word gap.
  - All other codes: unsupported.
- FSM states: IDLE, LOAD, MARK, SYM_GAP, CHAR_GAP, WORD_GAP.
  - IDLE: if hold_valid, go to LOAD.
  - LOAD (1 cycle): clear hold_valid; load the pattern shift register and remaining-element count.
    - Supported char: go to MARK with o_key<=1.
    - Space: go to WORD_GAP.
    - Unsupported: go to IDLE with no key activity.
  - MARK: o_key=1 for 1 unit (dot) or 3 units (dash). At expiry, o_key<=0 and shift the pattern.
    - Elements remain: go to SYM_GAP.
    - Otherwise: go to CHAR_GAP.
  - SYM_GAP: 1 unit off, then MARK.
  - CHAR_GAP: 3 units off, then IDLE.
  - WORD_GAP: 4 units off, then IDLE. Following a character's 3-unit gap this totals the standard 7.
- Unit timer: counts 0..UNIT_CYCLES-1 and restarts on every state entry. Duration in units is counted by a 2-bit unit counter, so every state time is an exact multiple of UNIT_CYCLES.
- Latency: if i_valid is first sampled high at edge N, hold_valid=1 after edge N+2, LOAD occurs at edge N+3, and o_key=1 after edge N+4.
- Key-on duration is exactly k*UNIT_CYCLES cycles, with no ±1 slip.
- o_busy = (state != IDLE) | hold_valid.
- Simultaneous events:
  - A byte edge during LOAD is accepted into the now-empty buffer, because clear and set occur on the same edge and set wins.
  - Back-to-back characters leave exactly 3 units of off-time between them.
- i_valid held high with no new edge produces no repeat keying.

Decomposition:
- Package morse_pkg holds:
  - FSM state enum.
  - Constants DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_EXTRA_UNITS=4.
  - ASCII_SPACE=8'h20.
  - Lookup result struct {supported, is_space, len[2:0], pat[4:0]}.
- Sub-module morse_lut: purely combinational ASCII-to-pattern ROM (case folding, digits, letters). It is instantiated once and verified standalone against the full 256-code table.

Test Plan (UNIT_CYCLES=4):
- 'E' (0x45), single i_valid rise -> o_key high 4 cycles, beginning after edge N+4; then 12 cycles low; then o_busy falls.
- 'A' (0x41) -> o_key 4 high, 4 low, 12 high, then 12 low before IDLE. Repeating with 'a' (0x61) gives an identical waveform.
- 'S','O' back-to-back (second rise while the first is keying) -> three 4-cycle dots, 12 low, three 12-cycle dashes; o_overflow stays 0.
- Three rises during 'O' -> the second byte is held, the third is dropped with a 1-cycle o_overflow pulse, and only two characters are keyed.
- '#' (0x23) then space (0x20) -> no o_key activity. '#' leaves IDLE 1 cycle after LOAD; space holds o_busy for 16 cycles.
- Assert i_rst_n=0 mid-dash -> o_key, o_busy and o_overflow go to 0 without waiting for a clock edge. After release, the bench sends 'T' and the block produces a clean 12-cycle mark.
